// File: rtl/hdlverifier_capture_pkg.sv
// Shared types for the multi-channel capture engine: FSM states, trigger
// mode encodings and the window-count clamp helper.
package hdlverifier_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_WDONE = 3'd4,
        ST_FULL  = 3'd5
    } capture_state_t;

    typedef enum logic [1:0] {
        TRIG_OR_LEVEL  = 2'b00,
        TRIG_AND_LEVEL = 2'b01,
        TRIG_OR_EDGE   = 2'b10,
        TRIG_RESERVED  = 2'b11
    } trig_mode_t;

    localparam int WIN_LOG2_W = 3;

    function automatic logic [WIN_LOG2_W-1:0] clamp_win(
        input logic [WIN_LOG2_W-1:0] win_log2,
        input logic [WIN_LOG2_W-1:0] max_log2
    );
        return (win_log2 > max_log2) ? max_log2 : win_log2;
    endfunction

endpackage

// File: rtl/hdlverifier_capture_mc_core_if.sv
// Readout port of the capture engine. HDLV_CAPTURE_TIMESTAMP_EN adds rd_ts.
interface hdlverifier_capture_mc_core_if #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int MAX_WIN_LOG2 = 3,
    parameter int TS_WIDTH     = 32
);
    // rd_req is a one-cycle request with no backpressure; rd_valid/rd_data
    // (and rd_ts) answer exactly one clock later, one response per request.
    logic                         rd_req;
    logic [MAX_WIN_LOG2-1:0]      rd_win;
    logic [ADDR_WIDTH-1:0]        rd_idx;
    logic                         rd_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
`ifdef HDLV_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]          rd_ts;

    modport master (output rd_req, rd_win, rd_idx, input rd_valid, rd_data, rd_ts);
    modport slave  (input rd_req, rd_win, rd_idx, output rd_valid, rd_data, rd_ts);
`else
    modport master (output rd_req, rd_win, rd_idx, input rd_valid, rd_data);
    modport slave  (input rd_req, rd_win, rd_idx, output rd_valid, rd_data);
`endif
endinterface

// File: rtl/hdlverifier_capture_ram.sv
// Simple dual-port sample buffer: one write port, registered read-first read port.
module hdlverifier_capture_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A same-address read in the write cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/hdlverifier_capture_mc_core.sv
// Windowed multi-channel capture engine with pre-trigger depth and masked
// trigger modes. Define HDLV_CAPTURE_TIMESTAMP_EN for per-window timestamps.
module hdlverifier_capture_mc_core
    import hdlverifier_capture_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int MAX_WIN_LOG2 = 3,
    parameter int TS_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data,
    input  logic [NUM_CH-1:0]            trigger,
    input  logic [NUM_CH-1:0]            trig_mask,
    input  logic [1:0]                   trig_mode,
    input  logic                         start,
    input  logic                         immediate,
    input  logic [2:0]                   win_log2,
    input  logic [ADDR_WIDTH-1:0]        trigger_pos,
    output logic                         ready_to_capture,
    output logic                         flag_full,
    output logic [MAX_WIN_LOG2:0]        captured_window_count,
    output capture_state_t               state_dbg,
    hdlverifier_capture_mc_core_if.slave rd
);
    localparam int WCW  = MAX_WIN_LOG2 + 1;
    localparam int NWIN = 2**MAX_WIN_LOG2;

    capture_state_t          state;
    logic                    start_d;
    logic [NUM_CH-1:0]       trigger_d;
    logic [2:0]              cfg_w;
    logic [ADDR_WIDTH-1:0]   cfg_p;
    trig_mode_t              cfg_mode;
    logic [NUM_CH-1:0]       cfg_mask;
    logic [MAX_WIN_LOG2-1:0] win_idx;
    logic [ADDR_WIDTH-1:0]   wptr, fill_cnt, post_cnt;
    logic [WCW-1:0]          win_count;
    logic [ADDR_WIDTH-1:0]   trig_addr [NWIN];
    logic                    rd_valid_q;

    logic [2:0]            w_new;
    logic [ADDR_WIDTH-1:0] p_new, wd_mask, p_eff, wptr_inc, waddr, raddr, rd_off;
    logic [NUM_CH-1:0]     masked;
    logic [WCW-1:0]        full_count;
    logic                  sel, hit, hit_arm, we;

    // Window base = idx * 2^(ADDR_WIDTH-W), computed as a shift of idx placed above the address bits.
    function automatic logic [ADDR_WIDTH-1:0] win_base(input logic [MAX_WIN_LOG2-1:0] idx,
                                                       input logic [2:0] w);
        logic [ADDR_WIDTH+MAX_WIN_LOG2-1:0] wide;
        wide = {idx, {ADDR_WIDTH{1'b0}}} >> w;
        return wide[ADDR_WIDTH-1:0];
    endfunction

    assign w_new      = clamp_win(win_log2, 3'(MAX_WIN_LOG2));
    assign p_new      = trigger_pos & ({ADDR_WIDTH{1'b1}} >> w_new);
    assign wd_mask    = {ADDR_WIDTH{1'b1}} >> cfg_w;
    assign p_eff      = cfg_p & wd_mask;
    assign wptr_inc   = (wptr + 1'b1) & wd_mask;
    assign full_count = WCW'(1) << cfg_w;
    assign waddr      = win_base(win_idx, cfg_w) | wptr;
    assign we         = start && clk_enable &&
                        (state == ST_FILL || state == ST_ARMED || state == ST_POST);

    always_comb begin
        masked = trigger & cfg_mask;
        case (cfg_mode)
            TRIG_AND_LEVEL: sel = (cfg_mask != '0) && (masked == cfg_mask);
            TRIG_OR_EDGE:   sel = |(masked & ~trigger_d);
            default:        sel = |masked;
        endcase
        hit     = clk_enable && (immediate || sel);
        hit_arm = start && (state == ST_ARMED) && hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_d   <= 1'b0;
            trigger_d <= '0;
            cfg_w     <= '0;
            cfg_p     <= '0;
            cfg_mode  <= TRIG_OR_LEVEL;
            cfg_mask  <= '0;
            win_idx   <= '0;
            wptr      <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            win_count <= '0;
            flag_full <= 1'b0;
            for (int i = 0; i < NWIN; i++) trig_addr[i] <= '0;
        end else begin
            start_d <= start;
            if (clk_enable) trigger_d <= trigger;
            if (!start) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (!start_d) begin
                        cfg_w     <= w_new;
                        cfg_p     <= trigger_pos;
                        cfg_mode  <= trig_mode_t'(trig_mode);
                        cfg_mask  <= trig_mask;
                        win_idx   <= '0;
                        wptr      <= '0;
                        fill_cnt  <= '0;
                        win_count <= '0;
                        flag_full <= 1'b0;
                        state     <= (p_new == '0) ? ST_ARMED : ST_FILL;
                    end
                    ST_FILL: if (clk_enable) begin
                        wptr     <= wptr_inc;
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt + 1'b1 == p_eff) state <= ST_ARMED;
                    end
                    ST_ARMED: if (clk_enable) begin
                        wptr <= wptr_inc;
                        if (hit) begin
                            trig_addr[win_idx] <= wptr;
                            post_cnt <= wd_mask - p_eff;
                            state    <= (wd_mask == p_eff) ? ST_WDONE : ST_POST;
                        end
                    end
                    ST_POST: if (clk_enable) begin
                        wptr     <= wptr_inc;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_WIDTH'(1)) state <= ST_WDONE;
                    end
                    ST_WDONE: begin
                        win_count <= win_count + 1'b1;
                        if (win_count + 1'b1 == full_count) begin
                            flag_full <= 1'b1;
                            state     <= ST_FULL;
                        end else begin
                            win_idx  <= win_idx + 1'b1;
                            wptr     <= '0;
                            fill_cnt <= '0;
                            state    <= (p_eff == '0) ? ST_ARMED : ST_FILL;
                        end
                    end
                    ST_FULL: state <= ST_FULL;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Logical index 0 is the oldest sample: P samples before the trigger address.
    assign rd_off = (trig_addr[rd.rd_win] - p_eff + rd.rd_idx) & wd_mask;
    assign raddr  = win_base(rd.rd_win, cfg_w) | rd_off;

    always_ff @(posedge clk) begin
        if (reset) rd_valid_q <= 1'b0;
        else       rd_valid_q <= rd.rd_req;
    end

    hdlverifier_capture_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_W    (NUM_CH*DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .waddr(waddr),
        .wdata(data),
        .re   (rd.rd_req),
        .raddr(raddr),
        .rdata(rd.rd_data)
    );

`ifdef HDLV_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_table [NWIN];
    logic [TS_WIDTH-1:0] rd_ts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt  <= '0;
            rd_ts_q <= '0;
            for (int i = 0; i < NWIN; i++) ts_table[i] <= '0;
        end else begin
            if (clk_enable) ts_cnt <= ts_cnt + 1'b1;
            if (hit_arm) ts_table[win_idx] <= ts_cnt;
            if (rd.rd_req) rd_ts_q <= ts_table[rd.rd_win];
        end
    end

    assign rd.rd_ts = rd_ts_q;
`endif

    assign rd.rd_valid             = rd_valid_q;
    assign ready_to_capture        = (state == ST_ARMED);
    assign captured_window_count   = win_count;
    assign state_dbg               = state;
endmodule

// File: doc/hdlverifier_capture_mc_core.md
Name: hdlverifier_capture_mc_core

Overview:
- Next-generation capture engine. Samples NUM_CH channels of DATA_WIDTH bits into one shared buffer.
- Buffer is split into 2^win_log2 equal windows. Each window has a programmable pre-trigger depth.
- Trigger is a masked, mode-selectable combination of per-channel trigger lines.
- Single-clock design: readout uses a clk-domain request/valid port. A host-side bridge (JTAG or AXI) sits outside this block.

Parameters:
- NUM_CH, 4, number of data/trigger channels (1..16).
- DATA_WIDTH, 8, bits per channel sample.
- ADDR_WIDTH, 6, log2 of total buffer depth in samples.
- MAX_WIN_LOG2, 3, maximum log2 window count; must be less than ADDR_WIDTH.
- TS_WIDTH, 32, timestamp width (optional feature only).

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  sample qualifier; no sampling or state advance when low.
- data  in  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- trigger  in  NUM_CH  per-channel trigger lines.
- trig_mask  in  NUM_CH  1 = channel participates in the trigger.
- trig_mode  in  2  00 masked OR level; 01 masked AND level; 10 masked OR rising edge; 11 treated as 00.
- start  in  1  rising edge arms a capture; low level aborts.
- immediate  in  1  trigger fires as soon as the window is armed.
- win_log2  in  3  log2 window count, clamped to MAX_WIN_LOG2.
- trigger_pos  in  ADDR_WIDTH  pre-trigger sample count, masked to window depth − 1.
- ready_to_capture  out  1  high in ARMED state.
- flag_full  out  1  all windows captured.
- captured_window_count  out  MAX_WIN_LOG2+1  completed windows.
- rd_req  in  1  read request.
- rd_win  in  MAX_WIN_LOG2  window index to read.
- rd_idx  in  ADDR_WIDTH  logical sample index within the window; 0 = oldest.
- rd_valid  out  1  read data valid.
- rd_data  out  NUM_CH*DATA_WIDTH  read data.

Behaviour:
- Reset: FSM to IDLE. All outputs 0. Window count 0. Trigger-address table cleared. Edge-detect register cleared.
- Derived values:
  - W = clamp(win_log2).
  - WD = 2^(ADDR_WIDTH−W).
  - P = trigger_pos & (WD−1).
  - Window base = win_idx*WD.
- Control inputs (win_log2, trigger_pos, trig_mode, trig_mask) are sampled on the start rising edge and held for the whole capture.
- FSM states:
  - IDLE: on start rising edge → FILL. Window index 0, write pointer 0, fill count 0.
  - FILL: write one sample per clk_enable. When fill count = P → ARMED. If P = 0, go directly to ARMED.
  - ARMED: keep writing circularly within the window. On a trigger hit, write the trigger sample, record its window-relative address in the table, load post-count = WD−P−1 → POST. If post-count is 0 → WDONE.
  - POST: write and decrement the post-count. At 0 → WDONE.
  - WDONE: one cycle, independent of clk_enable. Increment the window count.
    - If the count = 2^W → FULL and flag_full=1.
    - Otherwise advance the window and go to FILL.
  - FULL: hold until start is low → IDLE. flag_full and the window count persist until the next start rising edge, which clears them.
- Any state: start low → IDLE immediately. Partial window is discarded; completed windows remain readable.
- Trigger hit, evaluated only on clk_enable cycles:
  - OR and AND modes use the masked levels.
  - Edge mode uses trigger & ~trigger_d & mask. trigger_d updates on every clk_enable, in all states.
  - A mask of all zeros never hits, except with immediate=1.
  - immediate=1 hits on the first ARMED clk_enable cycle.
- A trigger during FILL is ignored; pre-trigger depth is guaranteed.
- Pipeline alignment: the sample written in the cycle of a hit is the data present in that cycle (zero-latency alignment).
- Read port:
  - One-cycle latency: rd_req at cycle n gives rd_valid and rd_data at n+1.
  - Physical address = base(rd_win) + ((trig_addr[rd_win] − P + rd_idx) mod WD).
  - rd_idx = P returns the trigger sample.
  - rd_idx ≥ WD wraps (mod WD).
  - Reads are legal in any state. Data for windows not yet completed is undefined, but rd_valid still asserts.
  - Simultaneous read and write to the same address returns the old data (read-first).

Optional Feature:
- Macro HDLV_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_WIDTH counter that increments on clk_enable and is cleared by reset.
  - Its value is latched per window on the trigger hit.
  - Adds output rd_ts [TS_WIDTH], returned with the same latency as rd_data, for rd_win.
- Undefined: no counter, no table, no rd_ts port.

Decomposition:
- Package hdlverifier_capture_pkg:
  - FSM state enum: IDLE, FILL, ARMED, POST, WDONE, FULL.
  - trig_mode encodings.
  - Window-clamp function.
- One sub-module, hdlverifier_capture_ram: simple dual-port, read-first, registered read, depth 2^ADDR_WIDTH, width NUM_CH*DATA_WIDTH.

Test Plan:
- W=0, P=16, mode 00, mask 0001, clk_enable=1, ch0 counter data, trigger[0] pulse at sample 40:
  - rd_idx 0..63 returns values 24..87.
  - rd_idx 16 returns 40.
  - flag_full=1.
  - captured_window_count=1.
- W=2 (WD=16), P=4, immediate=1:
  - Four windows complete in 4×16 + 4 cycles.
  - flag_full=1.
  - Each window reads back contiguous ramp data.
- Mode 01, mask 0011, trigger sequence 01, 10, 11:
  - Hit only on 11.
  - Mode 10 with trigger held high from arm: no hit until a low-to-high transition.
- Trigger asserted during FILL with P=8:
  - No hit.
  - Held trigger hits on the first ARMED cycle.
  - rd_idx 8 returns that sample.
- clk_enable toggling 1/0, P=4:
  - Only enabled-cycle samples are stored.
  - Post-count completes after exactly WD−P−1 enabled samples.
- start deasserted mid-POST of window 1 (W=1):
  - FSM returns to IDLE.
  - captured_window_count=1 and window 0 data stays intact.
  - A reset pulse then clears count and flags.
  - With HDLV_CAPTURE_TIMESTAMP_EN defined, rd_ts for window 0 equals the counter value at the hit.
